dds_lut_reader: RTL and testbench
=================================

Name: dds_lut_reader

Overview:
- Read-side counterpart of the reprogrammable waveform LUT, which is written from the pins.
- Holds a tuning word and a phase accumulator, and advances the phase on a programmable sample tick.
- Issues registered read strobes and addresses to the LUT read port and folds the quarter-wave LUT contents into a full-wave, offset-binary sample.
- Sits between the LUT read port and the DAC/output pins of the DDS top.

Parameters:
- PW, 12, phase accumulator and tuning word width.
- AW, 4, LUT address width (LUT depth 2^AW).
- WW, 6, LUT word width; the sample output is WW+1 bits.
- DIV, 4, clock cycles per sample tick (>=1).

Ports:
- clk  in  1  system clock.
- rst  in  1  synchronous, active-high reset.
- en  in  1  run enable.
- tw  in  PW  tuning word data.
- tw_load  in  1  latch tw into the internal tuning register.
- phase_clr  in  1  zero the phase accumulator.
- lut_re  out  1  LUT read enable, one-cycle pulse.
- lut_ra  out  AW  LUT read address.
- lut_rd  in  WW  LUT read data, valid one cycle after lut_re.
- sample_out  out  WW+1  offset-binary sample, midscale 2^WW.
- sample_valid  out  1  one-cycle pulse when sample_out updates.

Behaviour:
- Reset (rst=1 at a clk edge) values: acc=0, tw_reg=0, div_cnt=0, state=IDLE, lut_re=0, lut_ra=0, pipeline valids=0, sample_out=2^WW, sample_valid=0. Reset mid-pipeline drops all in-flight reads; no sample_valid follows.
- FSM, two states:
  - IDLE: div_cnt held at 0, no ticks. Go to RUN when en=1.
  - RUN: div_cnt increments each cycle. tick=1 when div_cnt==DIV-1, and div_cnt wraps to 0. Go to IDLE when en=0; div_cnt clears to 0.
  - In-flight pipeline stages always drain regardless of state.
- Tuning: tw_load=1 sets tw_reg<=tw, effective from the next tick. If tw_load and tick coincide, the tick uses the old tw_reg.
- Accumulator: on tick, acc <= acc + tw_reg, modulo 2^PW, wraps silently.
  - phase_clr=1 sets acc<=0 and has priority over tick; that tick still issues a read at phase 0.
- Address fold, computed from the post-update phase p:
  - q = p[PW-1:PW-2].
  - a = p[PW-3 -: AW].
  - lut_ra = q[0] ? ~a : a.
- Pipeline, for a tick in cycle T:
  - T+1: lut_re=1 and lut_ra valid (both registered); q captured.
  - T+2: lut_rd valid from the LUT, registered, read latency 1.
  - T+3: sample_out updated and sample_valid=1 for one cycle.
  - Sign: q[1]=0 gives 2^WW + lut_rd; q[1]=1 gives 2^WW - 1 - lut_rd. Neither case overflows WW+1 bits.
  - With DIV=1 there is one tick per cycle, fully pipelined, and throughput is 1 sample/cycle.
- en deasserting mid-pipeline: reads already issued complete normally; no new ticks are generated.
- sample_out holds its value between valid pulses.

Optional Feature:
- Macro: DDS_PHASE_OFFSET_EN.
- Defined:
  - Extra input phase_ofs [PW-1:0].
  - Address fold uses p' = acc_post + phase_ofs, modulo 2^PW; the accumulator itself is unaffected.
  - phase_ofs is sampled in the tick cycle T.
- Undefined: port absent; behaves as phase_ofs=0.

Decomposition:
- Package dds_pkg:
  - Default PW/AW/WW localparams.
  - typedef quadrant_t (2-bit).
  - Function midscale(WW) returning 2^WW.
  - Function fold_addr.
- One sub-module, dds_tick_div: the DIV counter, the IDLE/RUN FSM and tick generation.
- Accumulator, fold and sign stages stay in dds_lut_reader.

Test Plan:
All cases use PW=12, AW=4, WW=6 and a LUT model with rd = 4*addr, 1-cycle latency.
1. Reset: hold rst 2 cycles -> sample_out=64, sample_valid=0, lut_re=0, lut_ra=0.
2. DIV=1, tw_load tw=64, en=1 -> ticks at T: lut_ra=1 at T+1; sample_out=68 with sample_valid at T+3. Next samples are 72, 76, … one per cycle.
3. Quadrant 1: phase reaches 1088 (q=1, a=1) -> lut_ra=14, sample_out=64+56=120.
4. Quadrant 2: phase 2112 (q=2, a=1) -> lut_ra=1, sample_out=63-4=59. Quadrant 3 at phase 3136 -> lut_ra=14, sample_out=7.
5. Wrap: tw=4095 from acc=0 -> phase 4095 (q=3, a=15) gives lut_ra=0, sample_out=63. Next phase 4094, still lut_ra=0, then continues downward.
6. Simultaneous events:
   - phase_clr with tick -> lut_ra=0, sample_out=64.
   - tw_load(tw=128) on a tick cycle with old tw=64 -> that step +64, the next +128.
   - DIV=4, en dropped at T+1 after a tick -> that sample still appears at T+3, then no further lut_re.

Source files
------------

// File: rtl/dds_pkg.sv
// Shared types, default widths and helpers for the DDS LUT read path.
// The optional phase-offset input is enabled by defining DDS_PHASE_OFFSET_EN.
package dds_pkg;

  localparam int PW_DEF = 12;  // phase accumulator / tuning word width
  localparam int AW_DEF = 4;   // LUT address width
  localparam int WW_DEF = 6;   // LUT word width

  // Top two phase bits select the quadrant of the full wave.
  typedef logic [1:0] quadrant_t;

  // Sample-tick divider states.
  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_RUN  = 1'b1
  } run_state_t;

  // Offset-binary zero level for a WW-bit magnitude.
  function automatic int unsigned midscale(input int unsigned ww);
    return 32'd1 << ww;
  endfunction

  // Odd quadrants walk the quarter-wave table backwards.
  function automatic logic [31:0] fold_addr(input logic [31:0] a,
                                            input quadrant_t   q,
                                            input int unsigned aw);
    logic [31:0] mask;
    mask = (32'd1 << aw) - 32'd1;
    return (q[0] ? ~a : a) & mask;
  endfunction

endpackage : dds_pkg

// File: rtl/dds_tick_div.sv
// Sample-tick generator: IDLE/RUN state and a DIV-cycle counter.
// tick is high in the RUN cycle where the counter reaches DIV-1.
module dds_tick_div
  import dds_pkg::*;
#(
  parameter int DIV = 4
) (
  input  logic clk,
  input  logic rst,
  input  logic en,
  output logic tick
);

  localparam int            CW   = (DIV > 1) ? $clog2(DIV) : 1;
  localparam logic [CW-1:0] LAST = CW'(DIV - 1);

  run_state_t      state_q;
  logic [CW-1:0]   div_cnt_q;

  // State and divider counter; the counter only moves while running.
  always_ff @(posedge clk) begin
    // NOTE: state is updated with non-blocking assignments so every register
    // samples the pre-edge values, independent of statement order.
    if (rst) begin
      state_q   <= ST_IDLE;
      div_cnt_q <= '0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          div_cnt_q <= '0;
          if (en) state_q <= ST_RUN;
        end
        ST_RUN: begin
          if (!en) begin
            state_q   <= ST_IDLE;
            div_cnt_q <= '0;
          end else if (div_cnt_q == LAST) begin
            div_cnt_q <= '0;
          end else begin
            div_cnt_q <= div_cnt_q + CW'(1);
          end
        end
        default: begin
          state_q   <= ST_IDLE;
          div_cnt_q <= '0;
        end
      endcase
    end
  end

  // Tick is decoded purely from registered state.
  assign tick = (state_q == ST_RUN) && (div_cnt_q == LAST);

endmodule : dds_tick_div

// File: rtl/dds_lut_reader.sv
// DDS read side: tuning register, phase accumulator, quarter-wave address
// fold, LUT read strobe and full-wave offset-binary sample reconstruction.
// Define DDS_PHASE_OFFSET_EN to add the phase_ofs input (address-only offset).
module dds_lut_reader
  import dds_pkg::*;
#(
  parameter int PW  = PW_DEF,
  parameter int AW  = AW_DEF,
  parameter int WW  = WW_DEF,
  parameter int DIV = 4
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          en,
  input  logic [PW-1:0] tw,
  input  logic          tw_load,
  input  logic          phase_clr,
`ifdef DDS_PHASE_OFFSET_EN
  input  logic [PW-1:0] phase_ofs,
`endif
  output logic          lut_re,
  output logic [AW-1:0] lut_ra,
  input  logic [WW-1:0] lut_rd,
  output logic [WW:0]   sample_out,
  output logic          sample_valid
);

  localparam int          SW  = WW + 1;
  localparam int          FB  = AW + 2;
  localparam logic [WW:0] MID = SW'(midscale(WW));

  logic tick;

  // Tuning / phase state
  logic [PW-1:0] acc_q, acc_d;
  logic [PW-1:0] tw_q, tw_d;

  // Stage 1: read strobe, address, quadrant
  logic          lut_re_q, lut_re_d;
  logic [AW-1:0] lut_ra_q, lut_ra_d;
  quadrant_t     q1_q, q1_d;

  // Stage 2: read in flight inside the LUT
  logic          rd_pend_q, rd_pend_d;
  quadrant_t     q2_q, q2_d;

  // Stage 3: output sample
  logic [WW:0]   sample_q, sample_d;
  logic          sample_valid_q, sample_valid_d;

  // Quadrant and table index taken from the post-update phase.
  logic [FB-1:0] fold_bits;
  quadrant_t     fold_q;
  logic [AW-1:0] fold_a;
  logic [WW:0]   rd_ext;

  dds_tick_div #(
    .DIV (DIV)
  ) u_tick_div (
    .clk  (clk),
    .rst  (rst),
    .en   (en),
    .tick (tick)
  );

  // Tuning register and accumulator; phase_clr wins over a tick.
  always_comb begin
    // NOTE: every combinational output gets a default first so no path
    // leaves it unassigned, which would infer a latch.
    tw_d  = tw_load ? tw : tw_q;
    acc_d = acc_q;
    if (phase_clr) begin
      acc_d = '0;
    end else if (tick) begin
      acc_d = acc_q + tw_q;
    end
  end

  // Pick the top AW+2 bits of the (optionally offset) new phase.
`ifdef DDS_PHASE_OFFSET_EN
  always_comb fold_bits = FB'((acc_d + phase_ofs) >> (PW - FB));
`else
  always_comb fold_bits = FB'(acc_d >> (PW - FB));
`endif

  assign fold_q = fold_bits[FB-1 -: 2];
  assign fold_a = fold_bits[AW-1:0];
  assign rd_ext = {1'b0, lut_rd};

  // Next-state for the three read/fold/sign pipeline stages.
  always_comb begin
    lut_re_d       = tick;
    lut_ra_d       = lut_ra_q;
    q1_d           = q1_q;
    if (tick) begin
      lut_ra_d = AW'(fold_addr(32'(fold_a), fold_q, AW));
      q1_d     = fold_q;
    end

    rd_pend_d      = lut_re_q;
    q2_d           = lut_re_q ? q1_q : q2_q;

    sample_valid_d = rd_pend_q;
    sample_d       = sample_q;
    if (rd_pend_q) begin
      sample_d = q2_q[1] ? (MID - SW'(1) - rd_ext) : (MID + rd_ext);
    end
  end

  // All state registers; reset drops any reads still in flight.
  always_ff @(posedge clk) begin
    if (rst) begin
      acc_q          <= '0;
      tw_q           <= '0;
      lut_re_q       <= 1'b0;
      lut_ra_q       <= '0;
      q1_q           <= '0;
      rd_pend_q      <= 1'b0;
      q2_q           <= '0;
      sample_q       <= MID;
      sample_valid_q <= 1'b0;
    end else begin
      acc_q          <= acc_d;
      tw_q           <= tw_d;
      lut_re_q       <= lut_re_d;
      lut_ra_q       <= lut_ra_d;
      q1_q           <= q1_d;
      rd_pend_q      <= rd_pend_d;
      q2_q           <= q2_d;
      sample_q       <= sample_d;
      sample_valid_q <= sample_valid_d;
    end
  end

  assign lut_re       = lut_re_q;
  assign lut_ra       = lut_ra_q;
  assign sample_out   = sample_q;
  assign sample_valid = sample_valid_q;

endmodule : dds_lut_reader

// File: tb/tb_dds_lut_reader.sv
// Directed bench for dds_lut_reader: one DIV=1 instance for the datapath and
// one DIV=4 instance for the divider / enable-drop case. LUT model rd = 4*addr.
module tb_dds_lut_reader;

  localparam int PW = 12;
  localparam int AW = 4;
  localparam int WW = 6;

  logic clk = 1'b0;
  logic rst;

  // DIV=1 instance
  logic          en1, tw_load1, phase_clr1;
  logic [PW-1:0] tw1;
  logic          lut_re1, sample_valid1;
  logic [AW-1:0] lut_ra1;
  logic [WW-1:0] lut_rd1 = '0;
  logic [WW:0]   sample_out1;

  // DIV=4 instance
  logic          en4, tw_load4, phase_clr4;
  logic [PW-1:0] tw4;
  logic          lut_re4, sample_valid4;
  logic [AW-1:0] lut_ra4;
  logic [WW-1:0] lut_rd4 = '0;
  logic [WW:0]   sample_out4;

`ifdef DDS_PHASE_OFFSET_EN
  logic [PW-1:0] phase_ofs = '0;
`endif

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  dds_lut_reader #(.PW(PW), .AW(AW), .WW(WW), .DIV(1)) dut1 (
    .clk          (clk),
    .rst          (rst),
    .en           (en1),
    .tw           (tw1),
    .tw_load      (tw_load1),
    .phase_clr    (phase_clr1),
`ifdef DDS_PHASE_OFFSET_EN
    .phase_ofs    (phase_ofs),
`endif
    .lut_re       (lut_re1),
    .lut_ra       (lut_ra1),
    .lut_rd       (lut_rd1),
    .sample_out   (sample_out1),
    .sample_valid (sample_valid1)
  );

  dds_lut_reader #(.PW(PW), .AW(AW), .WW(WW), .DIV(4)) dut4 (
    .clk          (clk),
    .rst          (rst),
    .en           (en4),
    .tw           (tw4),
    .tw_load      (tw_load4),
    .phase_clr    (phase_clr4),
`ifdef DDS_PHASE_OFFSET_EN
    .phase_ofs    (phase_ofs),
`endif
    .lut_re       (lut_re4),
    .lut_ra       (lut_ra4),
    .lut_rd       (lut_rd4),
    .sample_out   (sample_out4),
    .sample_valid (sample_valid4)
  );

  // LUT models: one-cycle read latency, contents 4*addr.
  always @(posedge clk) begin
    if (lut_re1) lut_rd1 <= {lut_ra1, 2'b00};
    if (lut_re4) lut_rd4 <= {lut_ra4, 2'b00};
  end

  task automatic cyc(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  initial begin
    rst = 1'b1;
    en1 = 1'b0; tw1 = '0; tw_load1 = 1'b0; phase_clr1 = 1'b0;
    en4 = 1'b0; tw4 = '0; tw_load4 = 1'b0; phase_clr4 = 1'b0;

    // 1. Reset values
    cyc(2);
    check("rst_sample",   32'(sample_out1),   32'd64);
    check("rst_valid",    32'(sample_valid1), 32'd0);
    check("rst_re",       32'(lut_re1),       32'd0);
    check("rst_ra",       32'(lut_ra1),       32'd0);
    check("rst_sample4",  32'(sample_out4),   32'd64);

    // 2. DIV=1, tw=64: tick T is the first RUN cycle
    rst = 1'b0; tw1 = 12'd64; tw_load1 = 1'b1;
    cyc(1);
    tw_load1 = 1'b0; en1 = 1'b1;
    cyc(1);                                   // T
    cyc(1);                                   // T+1
    check("t1_re",        32'(lut_re1),       32'd1);
    check("t1_ra",        32'(lut_ra1),       32'd1);
    cyc(2);                                   // T+3
    check("t3_valid",     32'(sample_valid1), 32'd1);
    check("t3_sample",    32'(sample_out1),   32'd68);
    cyc(1);
    check("s72",          32'(sample_out1),   32'd72);
    check("s72_valid",    32'(sample_valid1), 32'd1);
    cyc(1);
    check("s76",          32'(sample_out1),   32'd76);

    // 3. Quadrant 1: phase 1088 (tick 16)
    cyc(12);
    check("q1_ra",        32'(lut_ra1),       32'd14);
    cyc(2);
    check("q1_sample",    32'(sample_out1),   32'd120);

    // 4. Quadrant 2: phase 2112 (tick 32); quadrant 3: phase 3136 (tick 48)
    cyc(14);
    check("q2_ra",        32'(lut_ra1),       32'd1);
    cyc(2);
    check("q2_sample",    32'(sample_out1),   32'd59);
    cyc(14);
    check("q3_ra",        32'(lut_ra1),       32'd14);
    cyc(2);
    check("q3_sample",    32'(sample_out1),   32'd7);

    // Stop: tick 51 (phase 3328, ra 11) still drains, sample 63-44=19 holds
    en1 = 1'b0;
    cyc(4);
    check("stop_re",      32'(lut_re1),       32'd0);
    check("stop_valid",   32'(sample_valid1), 32'd0);
    check("stop_hold",    32'(sample_out1),   32'd19);

    // 5. Wrap with tw=4095 from acc=0
    phase_clr1 = 1'b1;
    cyc(1);
    phase_clr1 = 1'b0; tw1 = 12'd4095; tw_load1 = 1'b1;
    cyc(1);
    tw_load1 = 1'b0; en1 = 1'b1;
    cyc(1);                                   // tick -> 4095
    cyc(1);
    check("wrap_ra0",     32'(lut_ra1),       32'd0);
    check("wrap_re",      32'(lut_re1),       32'd1);
    cyc(1);                                   // phase 4094
    check("wrap_ra1",     32'(lut_ra1),       32'd0);
    cyc(1);
    check("wrap_s0",      32'(sample_out1),   32'd63);
    cyc(1);
    check("wrap_s1",      32'(sample_out1),   32'd63);
    en1 = 1'b0;
    cyc(4);

    // 6a. phase_clr coinciding with a tick
    tw1 = 12'd64; tw_load1 = 1'b1;
    cyc(1);
    tw_load1 = 1'b0; en1 = 1'b1;
    cyc(1);                                   // tick C0
    phase_clr1 = 1'b1;
    cyc(1);                                   // C1
    phase_clr1 = 1'b0;
    check("clr_ra",       32'(lut_ra1),       32'd0);
    check("clr_re",       32'(lut_re1),       32'd1);
    cyc(1);                                   // C2: phase 64
    check("clr_next_ra",  32'(lut_ra1),       32'd1);
    cyc(1);                                   // C3
    check("clr_sample",   32'(sample_out1),   32'd64);
    check("clr_valid",    32'(sample_valid1), 32'd1);

    // 6b. tw_load on a tick: this step +64 (192), next +128 (320)
    tw1 = 12'd128; tw_load1 = 1'b1;
    cyc(1);                                   // C4
    tw_load1 = 1'b0;
    check("twl_ra_old",   32'(lut_ra1),       32'd3);
    cyc(1);                                   // C5
    check("twl_ra_new",   32'(lut_ra1),       32'd5);
    cyc(1);                                   // C6
    check("twl_s_old",    32'(sample_out1),   32'd76);
    cyc(1);                                   // C7
    check("twl_s_new",    32'(sample_out1),   32'd84);
    en1 = 1'b0;
    cyc(4);                                   // last tick phase 704 -> 108
    check("twl_hold",     32'(sample_out1),   32'd108);
    check("twl_idle",     32'(sample_valid1), 32'd0);

    // 6c. DIV=4, enable dropped at T+1 after a tick
    tw4 = 12'd64; tw_load4 = 1'b1;
    cyc(1);
    tw_load4 = 1'b0; en4 = 1'b1;
    cyc(1);                                   // RUN, count 0
    cyc(3);                                   // count 3: tick T
    check("d4_pre_re",    32'(lut_re4),       32'd0);
    cyc(1);                                   // T+1
    check("d4_re",        32'(lut_re4),       32'd1);
    check("d4_ra",        32'(lut_ra4),       32'd1);
    en4 = 1'b0;
    cyc(1);                                   // T+2
    check("d4_t2_re",     32'(lut_re4),       32'd0);
    cyc(1);                                   // T+3
    check("d4_valid",     32'(sample_valid4), 32'd1);
    check("d4_sample",    32'(sample_out4),   32'd68);
    for (int i = 0; i < 6; i++) begin
      cyc(1);
      check("d4_quiet_re",    32'(lut_re4),       32'd0);
      check("d4_quiet_valid", 32'(sample_valid4), 32'd0);
    end
    check("d4_hold",      32'(sample_out4),   32'd68);

    // Reset while a read is in flight: no sample_valid afterwards
    en1 = 1'b1;
    cyc(2);
    check("mid_re",       32'(lut_re1),       32'd1);
    rst = 1'b1; en1 = 1'b0;
    cyc(1);
    check("mid_rst_s",    32'(sample_out1),   32'd64);
    check("mid_rst_v",    32'(sample_valid1), 32'd0);
    check("mid_rst_re",   32'(lut_re1),       32'd0);
    check("mid_rst_ra",   32'(lut_ra1),       32'd0);
    rst = 1'b0;
    for (int i = 0; i < 3; i++) begin
      cyc(1);
      check("mid_drop_v", 32'(sample_valid1), 32'd0);
    end
    check("mid_drop_s",   32'(sample_out1),   32'd64);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule : tb_dds_lut_reader
